storage_write_arbiter: RTL and testbench

Two-requester round-robin arbiter and write sequencer for a shared WIDTH-bit posedge storage register.
- Grants exclusive write ownership to one requester at a time.
- Enforces a maximum consecutive-write hold so neither requester starves.
- Exposes the stored value and ownership status.
- Sits between producer blocks and a single D-flip-flop storage bank.

---
 rtl/storage_write_arbiter_pkg.sv | 14 +
 rtl/storage_write_arbiter_reg.sv | 21 ++
 rtl/storage_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_storage_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/storage_write_arbiter_pkg.sv
// Shared definitions for the storage write arbiter: FSM state encodings
// and the width of the consecutive-write hold counter.
package storage_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Hold counter is wide enough for MAX_HOLD up to 15.
    localparam int HOLD_W = 4;

endpackage

// File: rtl/storage_write_arbiter_reg.sv
// WIDTH-bit posedge storage register with write enable and async active-low clear.
module storage_write_arbiter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d only at enabled edges; d is ignored between edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/storage_write_arbiter.sv
// Two-requester round-robin write arbiter in front of one storage register.
// Optional write statistics counter: define STORAGE_ARB_STATS_EN.
//
// Handshake: a requester raises reqX and holds it for as long as it wants
// ownership. gntX is registered and rises the cycle after the request is
// sampled. A write of dX happens at every posedge where gntX and reqX are
// both high; data is not written at any other edge.
import storage_write_arbiter_pkg::*;

module storage_write_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [15:0]      wr_count
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    arb_state_t        state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_n;
    logic              last_owner;
    logic              wr_en;
    logic              wr_sel;
    logic [WIDTH-1:0]  wr_data;

    // State, hold counter, last owner and sticky valid flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
            q_valid    <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            if (state_n == ST_OWN0 && state != ST_OWN0) begin
                last_owner <= 1'b0;
            end else if (state_n == ST_OWN1 && state != ST_OWN1) begin
                last_owner <= 1'b1;
            end
            if (wr_en) begin
                q_valid <= 1'b1;
            end
        end
    end

    // Next-state, hold-counter update and write enable/select.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_n = last_owner ? ST_OWN0 : ST_OWN1;
                end else if (req0) begin
                    state_n = ST_OWN0;
                end else if (req1) begin
                    state_n = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req0) begin
                    state_n = req1 ? ST_OWN1 : ST_IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (req1) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = ST_OWN1;
                        end else begin
                            hold_n = hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_n = '0;
                    end
                end
            end
            ST_OWN1: begin
                wr_sel = 1'b1;
                if (!req1) begin
                    state_n = req0 ? ST_OWN0 : ST_IDLE;
                end else begin
                    wr_en = 1'b1;
                    if (req0) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = ST_OWN0;
                        end else begin
                            hold_n = hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_n = '0;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (state_n != state) begin
            hold_n = '0;
        end
    end

    assign gnt0    = (state == ST_OWN0);
    assign gnt1    = (state == ST_OWN1);
    assign wr_data = wr_sel ? d1 : d0;

    storage_write_arbiter_reg #(
        .WIDTH(WIDTH)
    ) u_storage_reg (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (wr_en),
        .d      (wr_data),
        .q      (q)
    );

`ifdef STORAGE_ARB_STATS_EN
    logic [15:0] wr_cnt_q;

    // Saturating count of write edges since reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= '0;
        end else if (wr_en && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    assign wr_count = wr_cnt_q;
`else
    assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_storage_write_arbiter.sv
// Self-checking bench for storage_write_arbiter: directed scenarios followed
// by random request/data traffic, all checked against a transaction-level model.
module tb_storage_write_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             reset_n;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [15:0]      wr_count;

    storage_write_arbiter #(
        .WIDTH   (WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .d0      (d0),
        .d1      (d1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .q       (q),
        .q_valid (q_valid),
        .wr_count(wr_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 nobody, else requester index. streak counts contested writes
    // by the current owner in its current tenure.
    int               m_owner;
    int               m_streak;
    int               m_last;
    logic [WIDTH-1:0] m_q;
    logic             m_valid;
    int               m_count;
    logic [WIDTH-1:0] exp_q[$];

    task automatic model_reset();
        m_owner  = -1;
        m_streak = 0;
        m_last   = 1;
        m_q      = '0;
        m_valid  = 1'b0;
        m_count  = 0;
    endtask

    // Apply one posedge worth of rules to the model using current inputs.
    task automatic model_step();
        bit               r[2];
        logic [WIDTH-1:0] dd[2];
        int               nxt;
        int               o;
        r[0]  = req0;
        r[1]  = req1;
        dd[0] = d0;
        dd[1] = d1;
        nxt   = m_owner;
        if (m_owner < 0) begin
            if (r[0] && r[1]) nxt = 1 - m_last;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
        end else begin
            o = m_owner;
            if (!r[o]) begin
                nxt = r[1-o] ? 1 - o : -1;
            end else begin
                m_q     = dd[o];
                m_valid = 1'b1;
                if (m_count < 65535) m_count++;
                if (r[1-o]) begin
                    m_streak++;
                    if (m_streak >= MAX_HOLD) nxt = 1 - o;
                end else begin
                    m_streak = 0;
                end
            end
        end
        if (nxt != m_owner) begin
            m_streak = 0;
            if (nxt >= 0) m_last = nxt;
        end
        m_owner = nxt;
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] eq;
        eq = exp_q.pop_front();
        check({tag, ".gnt0"}, 32'(gnt0), 32'(m_owner == 0));
        check({tag, ".gnt1"}, 32'(gnt1), 32'(m_owner == 1));
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".q_valid"}, 32'(q_valid), 32'(m_valid));
`ifdef STORAGE_ARB_STATS_EN
        check({tag, ".wr_count"}, 32'(wr_count), 32'(m_count));
`else
        check({tag, ".wr_count"}, 32'(wr_count), 32'h0);
`endif
    endtask

    // Drive one clock: model consumes current inputs, DUT sees the edge,
    // outputs are compared 1 ns after the edge.
    task automatic cycle(input string tag);
        model_step();
        exp_q.push_back(m_q);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] q_before;
    int               owner_before;

    initial begin
        reset_n = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        d0      = '0;
        d1      = '0;
        model_reset();
        #12;
        check("rst.gnt0", 32'(gnt0), 32'h0);
        check("rst.gnt1", 32'(gnt1), 32'h0);
        check("rst.q", 32'(q), 32'h0);
        check("rst.q_valid", 32'(q_valid), 32'h0);
        check("rst.wr_count", 32'(wr_count), 32'h0);
        reset_n = 1'b1;

        // Single requester for three edges.
        req0 = 1'b1;
        d0   = 8'hA5;
        for (int i = 0; i < 3; i++) cycle("single");
        check("single.q_a5", 32'(q), 32'hA5);

        // Async reset in the middle of a cycle while requester 0 owns.
        #3;
        reset_n = 1'b0;
        #1;
        check("async.gnt0", 32'(gnt0), 32'h0);
        check("async.q", 32'(q), 32'h0);
        check("async.q_valid", 32'(q_valid), 32'h0);
        model_reset();
        req0 = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First tie after reset, then sustained contention.
        req0 = 1'b1;
        req1 = 1'b1;
        d1   = 8'h3C;
        cycle("tie");
        check("tie.gnt0_first", 32'(gnt0), 32'h1);
        for (int i = 0; i < 4 * MAX_HOLD + 2; i++) begin
            d0 = WIDTH'($urandom_range(0, 255));
            cycle("fair");
        end

        // Early release: owner writes once more then drops req.
        cycle("pre_release");
        owner_before = m_owner;
        q_before     = m_q;
        if (owner_before == 0) begin
            req0 = 1'b0;
            d0   = 8'hEE;
        end else begin
            req1 = 1'b0;
            d1   = 8'hEE;
        end
        cycle("release");
        check("release.q_held", 32'(q), 32'(q_before));
        check("release.handoff", 32'(owner_before == 0 ? gnt1 : gnt0), 32'h1);

        // Glitchy data: only the value present at the edge is stored.
        req0 = 1'b1;
        req1 = 1'b0;
        d0   = 8'hFF;
        for (int i = 0; i < 3; i++) cycle("glitch_setup");
        d0 = 8'hFF;
        #1 d0 = 8'h00;
        #1 d0 = 8'hFF;
        #1 d0 = 8'h00;
        cycle("glitch");
        check("glitch.q_edge", 32'(q), 32'h00);

        // Random traffic with sticky requests.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            d0 = WIDTH'($urandom_range(0, 255));
            d1 = WIDTH'($urandom_range(0, 255));
            cycle("rand");
            check("rand.onehot", 32'(gnt0 & gnt1), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
